// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm unit and BCD time validation.
package alarm_pkg;

    localparam int unsigned TIME_W = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RINGING    = 2'd1,
        SNOOZE     = 2'd2,
        WAIT_CLEAR = 2'd3
    } alarm_state_e;

    typedef struct packed {
        logic [3:0] ms_hr;
        logic [3:0] ls_hr;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } bcd_time_t;

    localparam logic [7:0] LED_ALL_ON = 8'hFF;
    localparam logic [7:0] LED_SNOOZE = 8'h81;

    localparam logic [3:0] BCD_DIGIT_MAX      = 4'd9;
    localparam logic [3:0] BCD_MIN_TENS_MAX   = 4'd5;
    localparam logic [3:0] BCD_HR_TENS_MAX    = 4'd2;
    localparam logic [3:0] BCD_HR_UNITS_AT_20 = 4'd3;

endpackage

// File: rtl/bcd_time_valid.sv
// Combinational check that an HH:MM BCD value is a legal 24-hour time.
module bcd_time_valid
    import alarm_pkg::*;
(
    input  logic [TIME_W-1:0] bcd_time,
    output logic              valid
);

    bcd_time_t t;

    assign t = bcd_time_t'(bcd_time);

    always_comb begin
        valid = (t.ms_hr  <= BCD_HR_TENS_MAX)  &&
                (t.ls_hr  <= BCD_DIGIT_MAX)    &&
                (t.ms_min <= BCD_MIN_TENS_MAX) &&
                (t.ls_min <= BCD_DIGIT_MAX);
        // 20..23 is the only legal range once the tens-of-hours digit is 2
        if ((t.ms_hr == BCD_HR_TENS_MAX) && (t.ls_hr > BCD_HR_UNITS_AT_20)) begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/al_alarm_unit.sv
// Alarm register, time comparator and ring/snooze sequencer with LED pattern
// and display mux, all on the clk256 domain.
module al_alarm_unit
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SECONDS = 60,
    parameter int unsigned SNOOZE_MIN   = 9,
    parameter int unsigned BLINK_BITS   = 7
) (
    input  logic              clk256,
    input  logic              reset,
    input  logic              one_second,
    input  logic              one_minute,
    input  logic              load_alarm,
    input  logic [TIME_W-1:0] alarm_in,
    input  logic [TIME_W-1:0] current_time,
    input  logic              show_alarm,
    input  logic              alarm_enable,
    input  logic              stop,
    input  logic              snooze,
    output logic [TIME_W-1:0] alarm_time,
    output logic [TIME_W-1:0] display_time,
    output logic              ringing,
    output logic              snoozing,
    output logic              load_err,
    output logic [7:0]        led
);

    localparam int unsigned RING_W = 8;
    localparam int unsigned SNZ_W  = 6;

    alarm_state_e            state, state_d;
    logic [RING_W-1:0]       ring_cnt, ring_d;
    logic [SNZ_W-1:0]        snz_cnt, snz_d;
    logic [BLINK_BITS-1:0]   blink_cnt, blink_d;
    logic                    match_q;
    logic                    alarm_valid_c;
    logic                    load_ok_c;
    logic                    enter_ring_c;
    logic [TIME_W-1:0]       alarm_d, display_d;
    logic                    ringing_d, snoozing_d, load_err_d;
    logic [7:0]              led_d;

    bcd_time_valid u_alarm_valid (
        .bcd_time (alarm_in),
        .valid    (alarm_valid_c)
    );

    assign load_ok_c = load_alarm && alarm_valid_c;

    // State, counters and registered outputs
    always_ff @(posedge clk256) begin
        if (reset) begin
            state        <= IDLE;
            ring_cnt     <= '0;
            snz_cnt      <= '0;
            blink_cnt    <= '0;
            match_q      <= 1'b0;
            alarm_time   <= '0;
            display_time <= '0;
            ringing      <= 1'b0;
            snoozing     <= 1'b0;
            load_err     <= 1'b0;
            led          <= 8'h00;
        end else begin
            state        <= state_d;
            ring_cnt     <= ring_d;
            snz_cnt      <= snz_d;
            blink_cnt    <= blink_d;
            match_q      <= (current_time == alarm_time);
            alarm_time   <= alarm_d;
            display_time <= display_d;
            ringing      <= ringing_d;
            snoozing     <= snoozing_d;
            load_err     <= load_err_d;
            led          <= led_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        ring_d       = ring_cnt;
        snz_d        = snz_cnt;
        enter_ring_c = 1'b0;

        case (state)
            IDLE: begin
                if (alarm_enable && match_q) begin
                    state_d      = RINGING;
                    ring_d       = '0;
                    enter_ring_c = 1'b1;
                end
            end
            RINGING: begin
                if (!alarm_enable) begin
                    state_d = IDLE;
                end else if (load_ok_c || stop) begin
                    state_d = WAIT_CLEAR;
                end else if (snooze) begin
                    state_d = SNOOZE;
                    snz_d   = '0;
                end else if (one_second) begin
                    if (ring_cnt == RING_W'(RING_SECONDS - 1)) begin
                        state_d = WAIT_CLEAR;
                    end else begin
                        ring_d = ring_cnt + RING_W'(1);
                    end
                end
            end
            SNOOZE: begin
                if (!alarm_enable) begin
                    state_d = IDLE;
                end else if (load_ok_c || stop) begin
                    state_d = WAIT_CLEAR;
                end else if (one_minute) begin
                    if (snz_cnt == SNZ_W'(SNOOZE_MIN - 1)) begin
                        state_d      = RINGING;
                        ring_d       = '0;
                        enter_ring_c = 1'b1;
                    end else begin
                        snz_d = snz_cnt + SNZ_W'(1);
                    end
                end
            end
            WAIT_CLEAR: begin
                // Hold off until the matched minute has passed
                if (!match_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        blink_d    = enter_ring_c ? '0 : blink_cnt + BLINK_BITS'(1);
        alarm_d    = load_ok_c ? alarm_in : alarm_time;
        display_d  = show_alarm ? alarm_time : current_time;
        load_err_d = load_alarm && !alarm_valid_c;
        ringing_d  = (state_d == RINGING);
        snoozing_d = (state_d == SNOOZE);

        case (state_d)
            RINGING: led_d = blink_d[BLINK_BITS-1] ? 8'h00 : LED_ALL_ON;
            SNOOZE:  led_d = LED_SNOOZE;
            default: led_d = {7'b0, alarm_enable};
        endcase
    end

endmodule
